fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues IM requests, captures 1-cycle-latency returns and
// presents the two oldest entries. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int IW    = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [AW-1:0]            PC_init,
  input  logic                     FREEZE,
  input  logic                     taken_branch,
  input  logic [AW-1:0]            nextInstruction_address,
  output logic [AW-1:0]            Instr_address_2IM,
  output logic                     fetch_req,
  input  logic [IW-1:0]            Instr_fIM,
  input  logic [1:0]               deq_count,
  output logic [IW-1:0]            instr0,
  output logic [IW-1:0]            instr1,
  output logic [AW-1:0]            pc0,
  output logic [AW-1:0]            pc1,
  output logic                     valid0,
  output logic                     valid1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

  // Handshakes: fetch_req has no ready; the IM accepts every request and its word is
  // on Instr_fIM exactly one cycle later. deq_count is a consumer pull of 0-2 entries,
  // clamped to what is visible on valid0/valid1 and ignored while FREEZE is high.

  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];

  logic [PW-1:0] head_q, tail_q, head1;
  logic [CW-1:0] count_q, count_next, avail, deq_req, deq_n, pop_n;
  logic [CW:0]   occ;
  logic [AW-1:0] pc_q, inflight_addr_q, req_addr;
  logic          inflight_q;
  logic          ret_valid, bypass, wr_en, req;

  always_comb begin
    // a redirect squashes whatever the IM returns in the same cycle
    ret_valid = inflight_q && !taken_branch;
    occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    req       = !RESET && (taken_branch || (!FREEZE && (occ < DEPTH_OCC)));
    req_addr  = RESET ? PC_init : (taken_branch ? nextInstruction_address : pc_q);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass    = ret_valid && (count_q == '0);
`else
    bypass    = 1'b0;
`endif
    avail     = count_q + {{(CW-1){1'b0}}, bypass};
    deq_req   = {{(CW-2){1'b0}}, deq_count};
    deq_n     = FREEZE ? '0 : ((deq_req > avail) ? avail : deq_req);
    // a consumed bypass word is never stored, so no stored entry leaves the head
    pop_n      = bypass ? '0 : deq_n;
    wr_en      = ret_valid && !(bypass && (deq_n != '0));
    count_next = count_q + {{(CW-1){1'b0}}, wr_en} - pop_n;
    head1      = head_q + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q            <= PC_init;
      count_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= PC_init;
    end else begin
      if (taken_branch) begin
        count_q <= '0;
        head_q  <= tail_q;
      end else begin
        count_q <= count_next;
        head_q  <= head_q + pop_n[PW-1:0];
        if (wr_en) tail_q <= tail_q + PW'(1);
      end
      inflight_q <= req;
      if (req) begin
        pc_q            <= req_addr + AW'(4);
        inflight_addr_q <= req_addr;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && wr_en) begin
      instr_mem[tail_q] <= Instr_fIM;
      pc_mem[tail_q]    <= inflight_addr_q;
    end
  end

  always_comb begin
    Instr_address_2IM = req_addr;
    fetch_req         = req;
    valid0            = 1'b0;
    valid1            = 1'b0;
    instr0            = '0;
    instr1            = '0;
    pc0               = '0;
    pc1               = '0;
    count             = '0;
    if (!RESET) begin
      count  = count_q;
      valid0 = bypass || (count_q != '0);
      valid1 = count_q >= CW'(2);
      if (bypass) begin
        instr0 = Instr_fIM;
        pc0    = inflight_addr_q;
      end else if (count_q != '0) begin
        instr0 = instr_mem[head_q];
        pc0    = pc_mem[head_q];
      end
      if (valid1) begin
        instr1 = instr_mem[head1];
        pc1    = pc_mem[head1];
      end
    end
  end

endmodule
